// File: rtl/bus_datapath.sv
// Single-bus 32-bit CPU datapath: GPRs, special registers, I/O ports and ALU
// sharing one OR-combined internal bus, steered by one-hot control strobes.
module bus_datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic        MDRRead,
  input  logic        ALUen,
  input  logic        incPC,
  input  logic        BAOut,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R20out,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHIout,
  input  logic        ZLOout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        InportOut,
  input  logic        Cout,
  input  logic        r0ins,
  input  logic        r1ins,
  input  logic        r2ins,
  input  logic        r3ins,
  input  logic        r4ins,
  input  logic        r5ins,
  input  logic        r6ins,
  input  logic        r7ins,
  input  logic        r8ins,
  input  logic        r9ins,
  input  logic        r10ins,
  input  logic        r11ins,
  input  logic        r12ins,
  input  logic        r13ins,
  input  logic        r14ins,
  input  logic        r20ins,
  input  logic        HIins,
  input  logic        LOins,
  input  logic        PCins,
  input  logic        MARins,
  input  logic        IRins,
  input  logic        ZHIins,
  input  logic        ZLOins,
  input  logic        MDRins,
  input  logic        Inports,
  input  logic        Outports,
  input  logic [31:0] MDRMDataIn,
  output logic [31:0] OutportOut
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_ADDI = 5'b10001;
  localparam logic [4:0] OP_ANDI = 5'b10010;
  localparam logic [4:0] OP_ORI  = 5'b10011;
  localparam logic [4:0] OP_NEG  = 5'b10100;
  localparam logic [4:0] OP_NOT  = 5'b10101;

  // Slot 15 of the register array holds R20, so rb=15 selects it directly.
  logic [31:0] gpr_q [16];
  logic [31:0] hi_q, lo_q, zhi_q, zlo_q, pc_q, ir_q, mar_q, mdr_q;
  logic [31:0] inport_q, outport_q;
  logic [31:0] pc_d, mdr_d;

  logic [15:0] gpr_out_s, gpr_in_s;
  logic [31:0] bus_s, c_ext_s, a_s;
  logic [4:0]  opcode_s, sh_s;
  logic [31:0] sra_s;
  logic [63:0] rdbl_s, ldbl_s, mul_s, alu_s;
  logic        unused_s;

  assign gpr_out_s = {R20out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out & ~BAOut};
  assign gpr_in_s  = {r20ins, r14ins, r13ins, r12ins, r11ins, r10ins, r9ins, r8ins,
                      r7ins, r6ins, r5ins, r4ins, r3ins, r2ins, r1ins, r0ins};

  assign c_ext_s  = {{13{ir_q[18]}}, ir_q[18:0]};
  assign opcode_s = ir_q[31:27];
  assign a_s      = gpr_q[ir_q[22:19]];
  assign sh_s     = bus_s[4:0];
  assign sra_s    = $unsigned($signed(a_s) >>> sh_s);
  assign rdbl_s   = {a_s, a_s} >> sh_s;
  assign ldbl_s   = {a_s, a_s} << sh_s;
  assign mul_s    = {{32{a_s[31]}}, a_s} * {{32{bus_s[31]}}, bus_s};
  assign unused_s = ^{mar_q, ir_q[26:23]};

  // Bus: OR of every enabled source, zero when none drives.
  always_comb begin
    bus_s = 32'd0;
    for (int i = 0; i < 16; i++) begin
      bus_s = bus_s | (gpr_q[i] & {32{gpr_out_s[i]}});
    end
    bus_s = bus_s | (hi_q      & {32{HIout}})
                  | (lo_q      & {32{LOout}})
                  | (zhi_q     & {32{ZHIout}})
                  | (zlo_q     & {32{ZLOout}})
                  | (pc_q      & {32{PCout}})
                  | (mdr_q     & {32{MDRout}})
                  | (inport_q  & {32{InportOut}})
                  | (c_ext_s   & {32{Cout}});
  end

  // ALU: A from R[rb], B from the bus, 64-bit result.
  always_comb begin
    alu_s = 64'd0;
    case (opcode_s)
      OP_ADD, OP_ADDI: alu_s = {32'd0, a_s + bus_s};
      OP_SUB:          alu_s = {32'd0, a_s - bus_s};
      OP_AND, OP_ANDI: alu_s = {32'd0, a_s & bus_s};
      OP_OR,  OP_ORI:  alu_s = {32'd0, a_s | bus_s};
      OP_SHR:          alu_s = {32'd0, a_s >> sh_s};
      OP_SHRA:         alu_s = {32'd0, sra_s};
      OP_SHL:          alu_s = {32'd0, a_s << sh_s};
      OP_ROR:          alu_s = {32'd0, rdbl_s[31:0]};
      OP_ROL:          alu_s = {32'd0, ldbl_s[63:32]};
      OP_MUL:          alu_s = mul_s;
      OP_NEG:          alu_s = {32'd0, 32'd0 - bus_s};
      OP_NOT:          alu_s = {32'd0, ~bus_s};
      default:         alu_s = 64'd0;
    endcase
  end

  // Next-state for PC (load beats increment) and MDR (source select).
  always_comb begin
    if (PCins) begin
      pc_d = bus_s;
    end else if (incPC) begin
      pc_d = pc_q + 32'd1;
    end else begin
      pc_d = pc_q;
    end
    if (MDRins) begin
      mdr_d = MDRRead ? MDRMDataIn : bus_s;
    end else begin
      mdr_d = mdr_q;
    end
  end

  // Register file and special registers; clr wins over every load strobe.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        gpr_q[i] <= 32'd0;
      end
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      zhi_q     <= 32'd0;
      zlo_q     <= 32'd0;
      pc_q      <= 32'd0;
      ir_q      <= 32'd0;
      mar_q     <= 32'd0;
      mdr_q     <= 32'd0;
      inport_q  <= 32'd0;
      outport_q <= 32'd0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (gpr_in_s[i]) gpr_q[i] <= bus_s;
      end
      if (HIins)            hi_q      <= bus_s;
      if (LOins)            lo_q      <= bus_s;
      if (ALUen && ZHIins)  zhi_q     <= alu_s[63:32];
      if (ALUen && ZLOins)  zlo_q     <= alu_s[31:0];
      if (IRins)            ir_q      <= bus_s;
      if (MARins)           mar_q     <= bus_s;
      if (Inports)          inport_q  <= MDRMDataIn;
      if (Outports)         outport_q <= bus_s;
      pc_q  <= pc_d;
      mdr_q <= mdr_d;
    end
  end

  assign OutportOut = outport_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed self-checking bench for bus_datapath; registers are observed by
// routing them over the bus into the Outport.
module tb_bus_datapath;
  logic        clk = 1'b0;
  logic        clr, MDRRead, ALUen, incPC, BAOut;
  logic [15:0] gout, gin;
  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InportOut, Cout;
  logic        HIins, LOins, PCins, MARins, IRins, ZHIins, ZLOins, MDRins, Inports, Outports;
  logic [31:0] MDRMDataIn, OutportOut;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_datapath dut (
    .clk(clk), .clr(clr), .MDRRead(MDRRead), .ALUen(ALUen), .incPC(incPC), .BAOut(BAOut),
    .R0out(gout[0]), .R1out(gout[1]), .R2out(gout[2]), .R3out(gout[3]), .R4out(gout[4]),
    .R5out(gout[5]), .R6out(gout[6]), .R7out(gout[7]), .R8out(gout[8]), .R9out(gout[9]),
    .R10out(gout[10]), .R11out(gout[11]), .R12out(gout[12]), .R13out(gout[13]),
    .R14out(gout[14]), .R20out(gout[15]),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .InportOut(InportOut), .Cout(Cout),
    .r0ins(gin[0]), .r1ins(gin[1]), .r2ins(gin[2]), .r3ins(gin[3]), .r4ins(gin[4]),
    .r5ins(gin[5]), .r6ins(gin[6]), .r7ins(gin[7]), .r8ins(gin[8]), .r9ins(gin[9]),
    .r10ins(gin[10]), .r11ins(gin[11]), .r12ins(gin[12]), .r13ins(gin[13]),
    .r14ins(gin[14]), .r20ins(gin[15]),
    .HIins(HIins), .LOins(LOins), .PCins(PCins), .MARins(MARins), .IRins(IRins),
    .ZHIins(ZHIins), .ZLOins(ZLOins), .MDRins(MDRins), .Inports(Inports), .Outports(Outports),
    .MDRMDataIn(MDRMDataIn), .OutportOut(OutportOut)
  );

  task automatic clear_strobes();
    MDRRead = 1'b0; ALUen = 1'b0; incPC = 1'b0; BAOut = 1'b0;
    gout = 16'd0; gin = 16'd0;
    HIout = 1'b0; LOout = 1'b0; ZHIout = 1'b0; ZLOout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; InportOut = 1'b0; Cout = 1'b0;
    HIins = 1'b0; LOins = 1'b0; PCins = 1'b0; MARins = 1'b0; IRins = 1'b0;
    ZHIins = 1'b0; ZLOins = 1'b0; MDRins = 1'b0; Inports = 1'b0; Outports = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Source codes: 0-15 GPR (15 = R20), 16 HI, 17 LO, 18 ZHI, 19 ZLO,
  // 20 PC, 21 MDR, 22 Inport, 23 C.
  task automatic drive_src(input int code);
    if (code < 16) begin
      gout[code] = 1'b1;
    end else begin
      case (code)
        16: HIout = 1'b1;
        17: LOout = 1'b1;
        18: ZHIout = 1'b1;
        19: ZLOout = 1'b1;
        20: PCout = 1'b1;
        21: MDRout = 1'b1;
        22: InportOut = 1'b1;
        23: Cout = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic rd(input int code, output logic [31:0] v);
    clear_strobes();
    drive_src(code);
    Outports = 1'b1;
    step();
    clear_strobes();
    v = OutportOut;
  endtask

  task automatic put_inport(input logic [31:0] val);
    clear_strobes();
    MDRMDataIn = val;
    Inports = 1'b1;
    step();
    clear_strobes();
    InportOut = 1'b1;
  endtask

  task automatic ld_gpr(input int idx, input logic [31:0] val);
    put_inport(val);
    gin[idx] = 1'b1;
    step();
    clear_strobes();
  endtask

  task automatic ld_ir(input logic [31:0] val);
    put_inport(val);
    IRins = 1'b1;
    step();
    clear_strobes();
  endtask

  task automatic alu(input logic [31:0] ir, input int src);
    ld_ir(ir);
    drive_src(src);
    ALUen = 1'b1; ZLOins = 1'b1; ZHIins = 1'b1;
    step();
    clear_strobes();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    for (int i = 0; i < 16; i++) ld_gpr(i, 32'h00001000 + 32'(i));
    put_inport(32'h11111111); HIins = 1'b1; step();
    put_inport(32'h22222222); LOins = 1'b1; step();
    put_inport(32'h33333333); PCins = 1'b1; MARins = 1'b1; step();
    clear_strobes(); MDRMDataIn = 32'h44444444; MDRRead = 1'b1; MDRins = 1'b1; step();
    alu(32'h7800FFFF, 23);
    ld_ir(32'h0007ABCD);
    put_inport(32'h55555555); Outports = 1'b1; step();
    clear_strobes();
    clr = 1'b1; MDRMDataIn = 32'h66666666;
    InportOut = 1'b1; Outports = 1'b1; gin[6] = 1'b1; incPC = 1'b1; Inports = 1'b1;
    step();
    clr = 1'b0;
    clear_strobes();
    n_tests++;
    if (OutportOut !== 32'd0) begin
      n_fail++; $display("FAIL reset_outport: got %h expected %h", OutportOut, 32'd0);
    end
    for (int c = 0; c < 24; c++) begin
      rd(c, v);
      n_tests++;
      if (v !== 32'd0) begin
        n_fail++; $display("FAIL reset_src%0d: got %h expected %h", c, v, 32'd0);
      end
    end
  endtask

  task automatic test_imm_alu();
    logic [31:0] v;
    ld_gpr(0, 32'h00000012);
    alu(32'h88000136, 23);
    rd(19, v); n_tests++;
    if (v !== 32'h00000148) begin n_fail++; $display("FAIL addi: got %h expected %h", v, 32'h148); end
    alu(32'h900001FF, 23);
    rd(19, v); n_tests++;
    if (v !== 32'h00000012) begin n_fail++; $display("FAIL andi: got %h expected %h", v, 32'h12); end
    alu(32'h98000155, 23);
    rd(19, v); n_tests++;
    if (v !== 32'h00000157) begin n_fail++; $display("FAIL ori: got %h expected %h", v, 32'h157); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] v;
    ld_ir(32'h0007FFFF);
    Cout = 1'b1; gin[1] = 1'b1; step(); clear_strobes();
    rd(1, v); n_tests++;
    if (v !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sext_r1: got %h expected %h", v, 32'hFFFFFFFF); end
    ld_gpr(0, 32'h00000001);
    alu(32'h8807FFFF, 23);
    rd(19, v); n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL sext_addi_lo: got %h expected %h", v, 32'd0); end
  endtask

  task automatic test_mul();
    logic [31:0] v;
    ld_gpr(2, 32'h80000000);
    alu(32'h78100002, 23);
    rd(18, v); n_tests++;
    if (v !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mul_hi: got %h expected %h", v, 32'hFFFFFFFF); end
    rd(19, v); n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL mul_lo: got %h expected %h", v, 32'd0); end
    ld_ir(32'h78100003);
    Cout = 1'b1; ZHIins = 1'b1; ZLOins = 1'b1; ALUen = 1'b0; step(); clear_strobes();
    rd(18, v); n_tests++;
    if (v !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL aluen_hi: got %h expected %h", v, 32'hFFFFFFFF); end
    rd(19, v); n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL aluen_lo: got %h expected %h", v, 32'd0); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] v;
    logic [31:0] irs [7];
    logic [31:0] exp [7];
    irs[0] = 32'h40180004; exp[0] = 32'hFF000000;  // shra 4
    irs[1] = 32'h58180004; exp[1] = 32'h000000FF;  // rol 4
    irs[2] = 32'h50180008; exp[2] = 32'h0FF00000;  // ror 8
    irs[3] = 32'h20180004; exp[3] = 32'hF000000B;  // sub 4
    irs[4] = 32'h48180004; exp[4] = 32'h000000F0;  // shl 4
    irs[5] = 32'h38180004; exp[5] = 32'h0F000000;  // shr 4
    irs[6] = 32'hA0000001; exp[6] = 32'hFFFFFFFF;  // neg 1
    ld_gpr(3, 32'hF000000F);
    for (int k = 0; k < 7; k++) begin
      alu(irs[k], 23);
      rd(19, v); n_tests++;
      if (v !== exp[k]) begin n_fail++; $display("FAIL alu_op%0d: got %h expected %h", k, v, exp[k]); end
    end
    ld_gpr(15, 32'h00000005);
    alu(32'h18780003, 23);
    rd(19, v); n_tests++;
    if (v !== 32'h00000008) begin n_fail++; $display("FAIL add_r20: got %h expected %h", v, 32'h8); end
  endtask

  task automatic test_pc_baout();
    logic [31:0] v;
    put_inport(32'hFFFFFFFF); PCins = 1'b1; step(); clear_strobes();
    incPC = 1'b1; step(); clear_strobes();
    rd(20, v); n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL pc_wrap: got %h expected %h", v, 32'd0); end
    put_inport(32'h00000005); PCins = 1'b1; incPC = 1'b1; step(); clear_strobes();
    rd(20, v); n_tests++;
    if (v !== 32'h00000005) begin n_fail++; $display("FAIL pc_prio: got %h expected %h", v, 32'h5); end
    incPC = 1'b1; step(); step(); step(); clear_strobes();
    rd(20, v); n_tests++;
    if (v !== 32'h00000008) begin n_fail++; $display("FAIL pc_hold: got %h expected %h", v, 32'h8); end
    ld_gpr(0, 32'h00000012);
    BAOut = 1'b1; gout[0] = 1'b1; gin[2] = 1'b1; step(); clear_strobes();
    rd(2, v); n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL baout: got %h expected %h", v, 32'd0); end
    rd(0, v); n_tests++;
    if (v !== 32'h00000012) begin n_fail++; $display("FAIL r0_plain: got %h expected %h", v, 32'h12); end
  endtask

  task automatic test_mdr();
    logic [31:0] v;
    clear_strobes();
    MDRMDataIn = 32'hA5A5A5A5; MDRRead = 1'b1; MDRins = 1'b1; step(); clear_strobes();
    rd(21, v); n_tests++;
    if (v !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mdr_mem: got %h expected %h", v, 32'hA5A5A5A5); end
    ld_gpr(3, 32'h00000007);
    MDRMDataIn = 32'hDEADBEEF; gout[3] = 1'b1; MDRins = 1'b1; step(); clear_strobes();
    rd(21, v); n_tests++;
    if (v !== 32'h00000007) begin n_fail++; $display("FAIL mdr_bus: got %h expected %h", v, 32'h7); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    ld_gpr(0, 32'h00000012);
    alu(32'h88000001, 23);
    ZLOout = 1'b1; gin[3] = 1'b1; ALUen = 1'b1; ZLOins = 1'b1; step(); clear_strobes();
    rd(3, v); n_tests++;
    if (v !== 32'h00000013) begin n_fail++; $display("FAIL rmw_old_z: got %h expected %h", v, 32'h13); end
    rd(19, v); n_tests++;
    if (v !== 32'h00000025) begin n_fail++; $display("FAIL rmw_new_z: got %h expected %h", v, 32'h25); end
    ld_gpr(4, 32'h00000021);
    gout[0] = 1'b1; gout[4] = 1'b1; gin[5] = 1'b1; step(); clear_strobes();
    rd(5, v); n_tests++;
    if (v !== 32'h00000033) begin n_fail++; $display("FAIL bus_or: got %h expected %h", v, 32'h33); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_strobes();
    clr = 1'b1;
    MDRMDataIn = 32'd0;
    step();
    step();
    clr = 1'b0;
    test_reset();
    test_imm_alu();
    test_sign_ext();
    test_mul();
    test_alu_ops();
    test_pc_baout();
    test_mdr();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_datapath.md
# bus_datapath

Single-bus 32-bit CPU datapath: a general register file, special registers (PC, IR, MAR, MDR, HI, LO, 64-bit Z), an I/O port pair and an ALU share one 32-bit internal bus. The block is steered entirely by external one-hot control strobes from the control unit or a test sequencer. Its only external data paths are the memory/input data word `MDRMDataIn` and the registered output port `OutportOut`. Module name: `bus_datapath`.

## Interface
No parameters.
- `clk`  in  1  sole clock; all state updates on rising edge
- `clr`  in  1  synchronous active-high reset
- `MDRRead`  in  1  MDR load source select: 1 = `MDRMDataIn`, 0 = bus
- `ALUen`  in  1  enables Z loads
- `incPC`  in  1  PC <= PC + 1
- `BAOut`  in  1  base-address mode: R0 drives 0 on bus
- `R0out`..`R14out`, `R20out`  in  1 each  drive GPR R0..R14, R20 onto bus
- `HIout`, `LOout`, `ZHIout`, `ZLOout`, `PCout`, `MDRout`, `InportOut`  in  1 each  drive that register onto bus
- `Cout`  in  1  drive sign-extended IR[18:0] onto bus
- `r0ins`..`r14ins`, `r20ins`  in  1 each  load GPR from bus
- `HIins`, `LOins`, `PCins`, `MARins`, `IRins`  in  1 each  load register from bus
- `ZHIins`, `ZLOins`  in  1 each  load Z[63:32] / Z[31:0] from ALU result
- `MDRins`  in  1  load MDR (source per `MDRRead`)
- `Inports`  in  1  load Inport register from `MDRMDataIn`
- `Outports`  in  1  load Outport register from bus
- `MDRMDataIn`  in  32  memory/external input data word
- `OutportOut`  out  32  Outport register contents

## Operation
- Bus is combinational: the bitwise OR of all sources whose out-strobe is high; 0 when none is high. Control guarantees one-hot; OR behaviour on overlap is required, not an error.
- With `BAOut`=1, R0 contributes 0 even when `R0out`=1.
- `Cout` source: {13{IR[18]}, IR[18:0]}.
- IR fields: opcode IR[31:27], ra IR[26:23], rb IR[22:19], C IR[18:0].
- ALU operands: A = R[rb]. Index 15 maps to R20; index 0 reads R0 (not forced to 0). B = bus.
- ALU result is 64 bits; the high word is 0 except for mul. Opcodes:
  - 00011 add A+B; 00100 sub A−B
  - 00101 and; 00110 or
  - 00111 shr A>>B[4:0] logical; 01000 shra arithmetic; 01001 shl
  - 01010 ror; 01011 rol
  - 01111 mul, signed 64-bit A×B
  - 10001 addi A+B; 10010 andi A&B; 10011 ori A|B
  - 10100 neg −B; 10101 not ~B
  - any other opcode: 0
- Add/sub wrap mod 2^32 with no flags.
- Z loads require `ALUen`=1: `ZLOins` loads result[31:0]; `ZHIins` loads result[63:32].
- PC: `PCins` has priority over `incPC`; PC+1 wraps at 2^32.
- MAR is internal only, with no read path to the bus.

## Timing
- All registers are edge-triggered on rising `clk`. Loads sample the bus value present before the edge, so read-modify-write in one cycle is legal (e.g. `ZLOout` + `r3ins` while Z is being loaded uses the old Z).
- `clr`=1 at an edge zeroes every register: GPRs, HI, LO, Z, PC, IR, MAR, MDR, Inport, Outport. `OutportOut`=0 from the next edge.
- `clr` overrides all simultaneous load strobes. Asserting it mid-sequence discards all in-flight state.
- Latencies:
  - External word to a GPR: 2 cycles (`Inports` then `InportOut`+`rXins`).
  - ALU operation: 1 cycle, result available from Z the following cycle.
  - `OutportOut` updates 1 edge after `Outports`.
- Strobes may be held for multiple cycles. Repeated loads are idempotent unless the source changes. `incPC` increments once per edge while held.

## Test plan
- Reset: load arbitrary values, assert `clr` one edge -> every register reads 0 via its out-strobe; `OutportOut`=0.
- Immediate ALU:
  - Setup: `MDRMDataIn`=0x12, `Inports`; then `InportOut`+`r0ins` -> R0=0x12.
  - addi: IR=0x88000136; `Cout`+`ZLOins`+`ALUen`; then `ZLOout`+`Outports` -> `OutportOut`=0x148.
  - andi: IR=0x900001FF -> 0x12.
  - ori: IR=0x98000155 -> 0x157.
- Sign extension: IR C=0x7FFFF with `Cout`+`r1ins` -> R1=0xFFFFFFFF. Same IR with opcode 10001, R0=1 -> Z=0.
- mul high word: R[rb]=0x80000000, bus=2, opcode 01111; `ZHIins`+`ZLOins` -> ZHI=0xFFFFFFFF, ZLO=0. Same strobes with `ALUen`=0 -> Z unchanged.
- PC/BAOut:
  - `PCins` with bus=0xFFFFFFFF, then `incPC` -> PC=0.
  - `PCins`+`incPC` together with bus=5 -> PC=5.
  - R0=0x12, `BAOut`+`R0out`+`r2ins` -> R2=0.
- MDR source: `MDRRead`=1, `MDRins`, `MDRMDataIn`=0xA5A5A5A5 -> MDR=0xA5A5A5A5. `MDRRead`=0 with bus=R3=7 -> MDR=7.
